// File: rtl/somador_dr_pkg.sv
// Shared types for the dual-rail adder: handshake states, rail codewords
// and the single-bit dual-rail encoder.
package somador_dr_pkg;

  typedef enum logic {
    S_NULL = 1'b0,
    S_DATA = 1'b1
  } state_e;

  // Rail pair codewords, written as {t, f}.
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/dr_completion.sv
// Completion detector over W dual-rail pairs: reports whether every pair
// carries DATA, every pair is NULL, or any pair holds the illegal codeword.
module dr_completion
  import somador_dr_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] rail_t,
  input  logic [W-1:0] rail_f,
  output logic         all_data,
  output logic         all_null,
  output logic         any_illegal
);

  // NOTE: every variable written in always_comb gets a default before the
  // loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    all_data    = 1'b1;
    all_null    = 1'b1;
    any_illegal = 1'b0;
    for (int i = 0; i < W; i++) begin
      all_data    &= ({rail_t[i], rail_f[i]} == DR_0) ||
                     ({rail_t[i], rail_f[i]} == DR_1);
      all_null    &= ({rail_t[i], rail_f[i]} == DR_NULL);
      any_illegal |= ({rail_t[i], rail_f[i]} == DR_ILL);
    end
  end

endmodule

// File: rtl/somador_dr_sync.sv
// N-bit dual-rail ripple adder with a registered result and a two-state
// NULL/DATA handshake toward producer (ko) and consumer (ki).
module somador_dr_sync
  import somador_dr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A_t,
  input  logic [N-1:0] A_f,
  input  logic [N-1:0] B_t,
  input  logic [N-1:0] B_f,
  input  logic         Cin_t,
  input  logic         Cin_f,
  input  logic         ki,
  output logic [N-1:0] Soma_t,
  output logic [N-1:0] Soma_f,
  output logic         Cout_t,
  output logic         Cout_f,
  output logic         ko,
  output logic         err
);

  localparam int W = 2 * N + 1;

  logic [W-1:0] rail_t;
  logic [W-1:0] rail_f;
  logic         all_data;
  logic         all_null;
  logic         any_illegal;

  assign rail_t = {Cin_t, B_t, A_t};
  assign rail_f = {Cin_f, B_f, A_f};

  dr_completion #(.W(W)) u_completion (
    .rail_t      (rail_t),
    .rail_f      (rail_f),
    .all_data    (all_data),
    .all_null    (all_null),
    .any_illegal (any_illegal)
  );

  // Once the set is complete DATA the true rails are the binary operands.
  logic [N:0] sum_raw;
  logic [N:0] enc_t;
  logic [N:0] enc_f;

  assign sum_raw = {1'b0, A_t} + {1'b0, B_t} + {{N{1'b0}}, Cin_t};

  always_comb begin
    enc_t = '0;
    enc_f = '0;
    for (int i = 0; i <= N; i++) begin
      {enc_t[i], enc_f[i]} = dr_encode(sum_raw[i]);
    end
  end

  state_e       state_q, state_d;
  logic [N-1:0] soma_t_q, soma_t_d;
  logic [N-1:0] soma_f_q, soma_f_d;
  logic         cout_t_q, cout_t_d;
  logic         cout_f_q, cout_f_d;
  logic         ko_q, ko_d;
  logic         err_q, err_d;

  always_comb begin
    state_d  = state_q;
    soma_t_d = soma_t_q;
    soma_f_d = soma_f_q;
    cout_t_d = cout_t_q;
    cout_f_d = cout_f_q;
    ko_d     = ko_q;
    err_d    = any_illegal;
    unique case (state_q)
      S_NULL: begin
        if (all_data && ki && !any_illegal) begin
          state_d  = S_DATA;
          soma_t_d = enc_t[N-1:0];
          soma_f_d = enc_f[N-1:0];
          cout_t_d = enc_t[N];
          cout_f_d = enc_f[N];
          ko_d     = 1'b0;
        end
      end
      S_DATA: begin
        // A fresh DATA wavefront here is ignored: only NULL with ki low ends the phase.
        if (all_null && !ki) begin
          state_d  = S_NULL;
          soma_t_d = '0;
          soma_f_d = '0;
          cout_t_d = 1'b0;
          cout_f_d = 1'b0;
          ko_d     = 1'b1;
        end
      end
      default: state_d = S_NULL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_NULL;
      soma_t_q <= '0;
      soma_f_q <= '0;
      cout_t_q <= 1'b0;
      cout_f_q <= 1'b0;
      ko_q     <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      soma_t_q <= soma_t_d;
      soma_f_q <= soma_f_d;
      cout_t_q <= cout_t_d;
      cout_f_q <= cout_f_d;
      ko_q     <= ko_d;
      err_q    <= err_d;
    end
  end

  assign Soma_t = soma_t_q;
  assign Soma_f = soma_f_q;
  assign Cout_t = cout_t_q;
  assign Cout_f = cout_f_q;
  assign ko     = ko_q;
  assign err    = err_q;

endmodule

// File: tb/tb_somador_dr_sync.sv
// Directed bench for somador_dr_sync: a 4-bit instance for the handshake and
// arithmetic cases, and a 1-bit instance for the full-adder truth table.
module tb_somador_dr_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-bit instance
  logic [3:0] a_t, a_f, b_t, b_f, s_t, s_f;
  logic       cin_t, cin_f, ki, co_t, co_f, ko, err;

  somador_dr_sync #(.N(4)) dut4 (
    .clk(clk), .rst(rst),
    .A_t(a_t), .A_f(a_f), .B_t(b_t), .B_f(b_f),
    .Cin_t(cin_t), .Cin_f(cin_f), .ki(ki),
    .Soma_t(s_t), .Soma_f(s_f), .Cout_t(co_t), .Cout_f(co_f),
    .ko(ko), .err(err)
  );

  // 1-bit instance
  logic a1_t, a1_f, b1_t, b1_f, c1_t, c1_f, ki1;
  logic s1_t, s1_f, co1_t, co1_f, ko1, err1;

  somador_dr_sync #(.N(1)) dut1 (
    .clk(clk), .rst(rst),
    .A_t(a1_t), .A_f(a1_f), .B_t(b1_t), .B_f(b1_f),
    .Cin_t(c1_t), .Cin_f(c1_f), .ki(ki1),
    .Soma_t(s1_t), .Soma_f(s1_f), .Cout_t(co1_t), .Cout_f(co1_f),
    .ko(ko1), .err(err1)
  );

  // Observation words: {Soma_t, Soma_f, Cout_t, Cout_f, ko, err}
  logic [31:0] obs4, obs1;
  assign obs4 = {20'd0, s_t, s_f, co_t, co_f, ko, err};
  assign obs1 = {26'd0, s1_t, s1_f, co1_t, co1_f, ko1, err1};

  int tests_run = 0;
  int failed    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4_data(input logic [3:0] a, input logic [3:0] b, input logic c);
    a_t = a; a_f = ~a; b_t = b; b_f = ~b; cin_t = c; cin_f = ~c;
  endtask

  task automatic drive4_null();
    a_t = '0; a_f = '0; b_t = '0; b_f = '0; cin_t = 1'b0; cin_f = 1'b0;
  endtask

  task automatic drive1_null();
    a1_t = 0; a1_f = 0; b1_t = 0; b1_f = 0; c1_t = 0; c1_f = 0;
  endtask

  localparam logic [31:0] IDLE     = 32'h002;  // all NULL, ko=1
  localparam logic [31:0] IDLE_ERR = 32'h003;  // all NULL, ko=1, err=1

  initial begin
    drive4_null();
    drive1_null();
    ki  = 1'b1;
    ki1 = 1'b0;

    step();
    check("reset_values", obs4, IDLE);
    check("reset_values_n1", obs1, 32'h02);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_null_ki1", obs4, IDLE);
    end

    // 3 + 5 + 0 = 8
    drive4_data(4'd3, 4'd5, 1'b0);
    step();
    check("add_3_5", obs4, 32'h874);
    drive4_null();                       // NULL but ki still 1: wait
    step();
    check("data_hold_null_ki1", obs4, 32'h874);
    ki = 1'b0;
    step();
    check("return_null", obs4, IDLE);

    // Exhaustive full-adder truth table on the 1-bit instance
    for (int i = 0; i < 8; i++) begin
      logic a, b, c, s, co;
      a = i[2]; b = i[1]; c = i[0];
      s  = a ^ b ^ c;
      co = (a & b) | (a & c) | (b & c);
      a1_t = a; a1_f = ~a; b1_t = b; b1_f = ~b; c1_t = c; c1_f = ~c;
      ki1 = 1'b1;
      step();
      check($sformatf("n1_data_%0d", i), obs1, {26'd0, s, ~s, co, ~co, 2'b00});
      drive1_null();
      ki1 = 1'b0;
      step();
      check($sformatf("n1_null_%0d", i), obs1, 32'h02);
    end

    // 15 + 1 + 1 held with ki=0, then released: Soma=1, Cout=1
    drive4_data(4'd15, 4'd1, 1'b1);
    ki = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_ki0", obs4, IDLE);
    end
    ki = 1'b1;
    step();
    check("add_15_1_1_wrap", obs4, 32'h1E8);
    drive4_null();
    ki = 1'b0;
    step();
    check("return_null_2", obs4, IDLE);

    // Illegal pair on A[2] with the rest complete DATA
    drive4_data(4'd5, 4'd2, 1'b0);
    a_f[2] = 1'b1;
    ki = 1'b1;
    step();
    check("illegal_err_1", obs4, IDLE_ERR);
    step();
    check("illegal_err_2", obs4, IDLE_ERR);

    // Partial DATA: A repaired, B[0] left NULL
    drive4_data(4'd5, 4'd2, 1'b0);
    b_t[0] = 1'b0; b_f[0] = 1'b0;
    step();
    check("partial_no_err", obs4, IDLE);
    step();
    check("partial_hold", obs4, IDLE);

    // Complete it: 5 + 2 = 7, then a different DATA set is ignored
    drive4_data(4'd5, 4'd2, 1'b0);
    step();
    check("add_5_2", obs4, 32'h784);
    drive4_data(4'd1, 4'd1, 1'b0);
    step();
    check("ignore_new_data", obs4, 32'h784);

    // Reset while in S_DATA with DATA and ki=1 present
    rst = 1'b1;
    step();
    check("reset_mid_op", obs4, IDLE);
    rst = 1'b0;
    drive4_null();
    ki = 1'b1;
    step();
    check("after_reset_idle", obs4, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
